// File: rtl/fc_ctrl_pkg.sv
// Shared types and default sizing for the fully-connected classification controller.
// Class indices follow the order the weight sets are loaded for the shape classifier.
package fc_ctrl_pkg;

  localparam int DEF_NUM_CLASSES = 4;
  localparam int DEF_WEIGHT_W    = 64;
  localparam int DEF_RESULT_W    = 8;
  localparam int DEF_FC_LATENCY  = 1;

  typedef enum logic [1:0] {
    CLS_X      = 2'd0,
    CLS_O      = 2'd1,
    CLS_SLASH  = 2'd2,
    CLS_BSLASH = 2'd3
  } class_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/fc_argmax_tracker.sv
// Running signed argmax over the class scores of one inference.
// win_idx/win_score include the score being sampled this cycle, so the caller can latch the final winner on the last sample edge.
module fc_argmax_tracker
  import fc_ctrl_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int RESULT_W    = DEF_RESULT_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           sample,
  input  logic [$clog2(NUM_CLASSES)-1:0] idx,
  input  logic [RESULT_W-1:0]            score,
  output logic [$clog2(NUM_CLASSES)-1:0] win_idx,
  output logic [RESULT_W-1:0]            win_score
);

  localparam int IDX_W = $clog2(NUM_CLASSES);

  logic [IDX_W-1:0]    best_idx;
  logic [RESULT_W-1:0] best_score;
  logic                take;

  // Strictly-greater replacement keeps the lowest index on ties; idx 0 seeds the search.
  assign take = sample && ((idx == '0) || ($signed(score) > $signed(best_score)));

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_idx   = best_idx;
    win_score = best_score;
    if (take) begin
      win_idx   = idx;
      win_score = score;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_idx   <= '0;
      best_score <= '0;
    end else if (clr) begin
      best_idx   <= '0;
      best_score <= '0;
    end else if (sample) begin
      best_idx   <= win_idx;
      best_score <= win_score;
    end
  end

endmodule

// File: rtl/fc_classify_sequencer.sv
// Walks the shared FC neuron through every class weight vector and reports the signed argmax.
// The pooled pixel array is held stable upstream while busy is high.
module fc_classify_sequencer
  import fc_ctrl_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int WEIGHT_W    = DEF_WEIGHT_W,
  parameter int RESULT_W    = DEF_RESULT_W,
  parameter int FC_LATENCY  = DEF_FC_LATENCY
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_CLASSES)-1:0] cfg_addr,
  input  logic [WEIGHT_W-1:0]            cfg_wdata,
  output logic [WEIGHT_W-1:0]            weight_o,
  input  logic [RESULT_W-1:0]            fc_result_i,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(NUM_CLASSES)-1:0] class_id,
  output logic [RESULT_W-1:0]            class_score
);

  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam int LAT_W = (FC_LATENCY > 1) ? $clog2(FC_LATENCY) : 1;

  seq_state_e          state, state_d;
  logic [WEIGHT_W-1:0] wreg [NUM_CLASSES];
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [LAT_W-1:0]    lat_cnt;
  logic                launch, advance, sample, last_cls, lat_hit;
  logic [IDX_W-1:0]    win_idx;
  logic [RESULT_W-1:0] win_score;

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign idx_nxt  = idx + 1'b1;
  assign last_cls = (idx == IDX_W'(NUM_CLASSES - 1));
  assign lat_hit  = (lat_cnt == LAT_W'(FC_LATENCY - 1));

  // NOTE: the weight file is reset like any other control state so a fresh power-up never drives stale vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) wreg[i] <= '0;
    end else if (cfg_we && !busy) begin
      wreg[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    launch  = 1'b0;
    advance = 1'b0;
    sample  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          launch  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (lat_hit) begin
          sample = 1'b1;
          if (last_cls) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      lat_cnt     <= '0;
      weight_o    <= '0;
      class_id    <= '0;
      class_score <= '0;
    end else begin
      if (state == ISSUE)     lat_cnt <= '0;
      else if (state == WAIT) lat_cnt <= lat_cnt + 1'b1;

      if (launch) begin
        idx      <= '0;
        weight_o <= wreg[0];
      end else if (advance) begin
        idx      <= idx_nxt;
        weight_o <= wreg[idx_nxt];
      end else if (state == DONE) begin
        weight_o <= '0;
      end

      // The winner is latched only on the final sample, so it holds through idle and later runs.
      if (sample && last_cls) begin
        class_id    <= win_idx;
        class_score <= win_score;
      end
    end
  end

  fc_argmax_tracker #(
    .NUM_CLASSES (NUM_CLASSES),
    .RESULT_W    (RESULT_W)
  ) u_argmax (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (launch),
    .sample    (sample),
    .idx       (idx),
    .score     (fc_result_i),
    .win_idx   (win_idx),
    .win_score (win_score)
  );

endmodule

// File: tb/tb_fc_classify_sequencer.sv
// Scoreboard bench: a stub FC neuron answers each weight vector one edge later; the
// expected winner for each start is queued and a negedge monitor checks every done pulse.
module tb_fc_classify_sequencer;

  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [63:0] cfg_wdata;
  logic [63:0] weight_o;
  logic [7:0]  fc_result_i;
  logic        busy;
  logic        done;
  logic [1:0]  class_id;
  logic [7:0]  class_score;

  typedef struct {
    logic [1:0] id;
    logic [7:0] score;
    int         cyc;
  } exp_t;

  exp_t        q[$];
  logic [63:0] wmod [NC];
  logic [7:0]  res  [NC];
  logic [63:0] w_cap;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  fc_classify_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .weight_o    (weight_o),
    .fc_result_i (fc_result_i),
    .busy        (busy),
    .done        (done),
    .class_id    (class_id),
    .class_score (class_score)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub neuron: the score for a weight vector appears one edge after it is presented.
  function automatic logic [7:0] lookup(input logic [63:0] w);
    for (int k = 0; k < NC; k++) if (wmod[k] == w) return res[k];
    return 8'h5A;
  endfunction

  always @(negedge clk) w_cap = weight_o;
  always @(posedge clk) begin
    #1 fc_result_i = lookup(w_cap);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy) check("idle_weight_zero", weight_o, 64'd0);
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("class_id", 64'(class_id), 64'(e.id));
          check("class_score", 64'(class_score), 64'(e.score));
          check("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic cfg_write(input int a, input logic [63:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    wmod[a] = d;
  endtask

  task automatic program_plan();
    cfg_write(0, 64'h01ffff01_ff0101ff);
    cfg_write(1, 64'hff0101ff_01ffff01);
    cfg_write(2, 64'hffffffff_ff0101ff);
    cfg_write(3, 64'h01ffff01_ffffffff);
  endtask

  task automatic program_random();
    for (int k = 0; k < NC; k++) begin
      logic [63:0] w;
      bit          clash;
      do begin
        w = {$urandom, $urandom};
        clash = (w == 64'd0);
        for (int j = 0; j < k; j++) if (wmod[j] == w) clash = 1'b1;
      end while (clash);
      cfg_write(k, w);
    end
  endtask

  function automatic logic [7:0] rand_res();
    logic [7:0] pool [6];
    pool = '{8'h80, 8'h81, 8'h7F, 8'h00, 8'hFF, 8'h03};
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 5)];
    return 8'($urandom);
  endfunction

  task automatic do_run(input logic [7:0] r0, r1, r2, r3,
                        input bit extra_starts, input bit busy_write, input bit mid_reset);
    exp_t       e;
    int         best;
    logic [7:0] resp [NC];
    res[0] = r0; res[1] = r1; res[2] = r2; res[3] = r3;
    for (int k = 0; k < NC; k++) resp[k] = lookup(wmod[k]);
    best = 0;
    for (int k = 1; k < NC; k++) if ($signed(resp[k]) > $signed(resp[best])) best = k;
    @(negedge clk);
    e.id = 2'(best); e.score = resp[best]; e.cyc = cyc + 9;
    q.push_back(e);
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      cfg_we = 1'b0;
      if (mid_reset && c == 4) begin
        rst_n = 1'b0;
        q.delete(q.size() - 1);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_weight", weight_o, 64'd0);
        check("rst_class_id", 64'(class_id), 64'd0);
        check("rst_class_score", 64'(class_score), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NC; k++) wmod[k] = 64'd0;
        return;
      end
      if (c <= 8) check("weight_walk", weight_o, wmod[(c - 1) / 2]);
      check("busy", 64'(busy), 64'(c <= 9));
      if (extra_starts && (c == 3 || c == 8 || c == 9)) start = 1'b1;
      if (busy_write && c == 4) begin
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = '1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    fc_result_i = '0;
    for (int k = 0; k < NC; k++) begin wmod[k] = '0; res[k] = '0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_weight", weight_o, 64'd0);
    check("reset_class_id", 64'(class_id), 64'd0);
    check("reset_class_score", 64'(class_score), 64'd0);

    program_plan();
    do_run(8'h04, 8'hFC, 8'h00, 8'h02, 0, 0, 0);
    do_run(8'h80, 8'h81, 8'hFF, 8'h90, 0, 0, 0);
    do_run(8'h03, 8'h03, 8'hFF, 8'h03, 0, 0, 0);
    do_run(8'h10, 8'h7F, 8'h80, 8'h7F, 1, 0, 0);

    do_run(8'h01, 8'h02, 8'h03, 8'h04, 0, 1, 0);
    do_run(8'h05, 8'h01, 8'h05, 8'h06, 0, 0, 0);
    cfg_write(1, '1);
    do_run(8'h00, 8'h40, 8'h3F, 8'h80, 0, 0, 0);

    do_run(8'h20, 8'h30, 8'h40, 8'h50, 0, 0, 1);
    do_run(8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0);
    program_plan();
    do_run(8'h04, 8'hFC, 8'h00, 8'h02, 0, 0, 0);

    for (int r = 0; r < 30; r++) begin
      if (r % 5 == 0) program_random();
      do_run(rand_res(), rand_res(), rand_res(), rand_res(), ($urandom_range(0, 3) == 0), 0, 0);
    end

    repeat (3) @(negedge clk);
    check("pending_done", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_classify_sequencer.md
Name: fc_classify_sequencer

Overview:
- Sequences the shared fully-connected neuron (FCNeuron) across all output classes of the shape classifier (X, O, /, \).
- Per inference, presents each class weight vector to the neuron in turn, samples the neuron's result and keeps a running signed argmax.
- Reports the winning class and its score with a one-cycle done pulse.
- Sits between the pooling stage, whose pooled pixel array is held stable by the upstream block during busy, and the classification output.

Parameters:
NUM_CLASSES, 4, number of weight sets / output classes
WEIGHT_W, 64, width of one class weight vector (2 kernels x 4 pixels x 8 bits)
RESULT_W, 8, width of neuron result, two's-complement signed
FC_LATENCY, 1, clock edges from weight_o change to valid fc_result_i (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to classify current pooled array
cfg_we  input  1  weight register write enable
cfg_addr  input  $clog2(NUM_CLASSES)  class index to write
cfg_wdata  input  WEIGHT_W  weight vector to store
weight_o  output  WEIGHT_W  weight vector driven to FCNeuron.weight
fc_result_i  input  RESULT_W  FCNeuron.result
busy  output  1  sequence in progress
done  output  1  one-cycle pulse, class_id/class_score valid
class_id  output  $clog2(NUM_CLASSES)  index of winning class
class_score  output  RESULT_W  signed result of winning class

Behaviour:
- Reset (async assert, sync deassert by the flop): state=IDLE, busy=0, done=0, weight_o=0, class_id=0, class_score=0, idx=0, lat_cnt=0, all weight registers=0.
- Weight register file: NUM_CLASSES x WEIGHT_W flops. Written on clk when cfg_we=1 and busy=0. Writes while busy=1 are dropped. Writes take effect on the next inference.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: start=1 -> idx=0, weight_o<=wreg[0], busy<=1, go ISSUE. start while busy=1 or in DONE is ignored; no queuing.
- ISSUE: first cycle with weight_o=wreg[idx]. lat_cnt<=0, go WAIT.
- WAIT: lat_cnt increments each edge. When lat_cnt==FC_LATENCY-1, sample fc_result_i on that edge into the argmax.
  - If idx==NUM_CLASSES-1: go DONE and register class_id/class_score from the final argmax.
  - Else: idx++, weight_o<=wreg[idx+1], go ISSUE.
- Per class: FC_LATENCY+1 edges. done is high during cycle NUM_CLASSES*(FC_LATENCY+1) after the start-sampling edge (defaults: 8).
- DONE: done=1 for exactly one cycle, busy<=0, weight_o<=0, go IDLE. start in the DONE cycle is ignored.
- Argmax rule:
  - idx 0 loads best unconditionally.
  - Later indices replace best only if strictly greater (signed compare).
  - Ties keep the lowest index.
  - 0x80 (-128) is a legal score.
- class_id/class_score are updated only at entry to DONE and hold until the next DONE or reset.
- Reset mid-operation: immediate return to reset values. No done is produced, and the partial argmax is discarded.
- weight_o is registered and equals 0 whenever busy=0.

Decomposition:
- Package fc_ctrl_pkg:
  - NUM_CLASSES, WEIGHT_W, RESULT_W defaults
  - class_e enum: CLS_X=0, CLS_O=1, CLS_SLASH=2, CLS_BSLASH=3
  - seq_state_e enum: IDLE, ISSUE, WAIT, DONE
- Sub-module fc_argmax_tracker: clk, rst_n, clr, sample, idx, score.
  - Holds best_idx/best_score.
  - Signed strict-greater compare; clr on start.

Test Plan:
- Load class weights 0x01ffff01_ff0101ff, 0xff0101ff_01ffff01, 0xffffffff_ff0101ff, 0x01ffff01_ffffffff. Start with the stub neuron returning 0x04,0xFC,0x00,0x02 -> weight_o walks the 4 vectors for 2 cycles each; done exactly 8 cycles after start; class_id=0, class_score=0x04.
- Results 0x80,0x81,0xFF,0x90 -> class_id=2, class_score=0xFF (all-negative signed argmax).
- Results 0x03,0x03,0xFF,0x03 -> class_id=0, class_score=0x03 (tie keeps lowest index).
- start pulsed again at cycles 3 and 8 of a run -> ignored; single done; busy falls the cycle after done.
- rst_n low at cycle 4 of a run -> busy=0, weight_o=0, class_id/score=0, no done. Next start completes normally in 8 cycles.
- cfg_we to class 1 with 0xffffffff_ffffffff while busy -> dropped; readback via the next run's weight_o shows the original value. The same write while idle is applied.
